// File: rtl/hub75_pkg.sv
// Shared types, constants and width helpers for the HUB75 scan sequencer.
package hub75_pkg;

  localparam int unsigned COLS_PER_PANEL = 32;
  localparam int unsigned COL_W          = 8;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t S_IDLE     = 3'd0;
  localparam scan_state_t S_SHIFT_LO = 3'd1;
  localparam scan_state_t S_SHIFT_HI = 3'd2;
  localparam scan_state_t S_BLANK    = 3'd3;
  localparam scan_state_t S_LATCH    = 3'd4;
  localparam scan_state_t S_DISPLAY  = 3'd5;

  // Index width for n items, at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Display timer width: holds the longest on-time (BASE_ON << (BPP-1)).
  function automatic int unsigned timer_w(input int unsigned base_on, input int unsigned bpp);
    return $clog2(base_on << (bpp - 1)) + 1;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// OE on-time down-counter: loaded with the plane weight, done_c flags the last on clock.
module hub75_oe_timer #(
  parameter int unsigned TW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          run,
  output logic          done_c
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done_c = run && (cnt == TW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: shifts each row pair once per bit-plane, latches it and
// displays it for BASE_ON<<plane clocks (binary-code modulation).
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter  int unsigned NUM_PANELS = 1,
  parameter  int unsigned ROW_PAIRS  = 8,
  parameter  int unsigned BPP        = 4,
  parameter  int unsigned BASE_ON    = 8,
  localparam int unsigned RA         = idx_w(ROW_PAIRS),
  localparam int unsigned PB         = idx_w(BPP)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [COL_W-1:0]        col,
  input  logic                    colct_eq_max,
  output logic                    colct_clr,
  output logic                    colct_enb,
  output logic                    fb_rd_en,
  output logic [RA+PB+COL_W-1:0]  fb_addr,
  output logic                    sclk,
  output logic                    lat,
  output logic                    oe_n,
  output logic [RA-1:0]           row_addr,
  output logic [PB-1:0]           plane,
  output logic                    frame_done
);

  localparam int unsigned TW       = timer_w(BASE_ON, BPP);
  localparam int unsigned LAST_COL = NUM_PANELS * COLS_PER_PANEL - 1;

  scan_state_t   state, state_d;
  logic [RA-1:0] shift_row, shift_row_d, row_addr_d;
  logic [PB-1:0] plane_d;
  logic          sclk_d, lat_d, oe_n_d, fb_rd_en_d, colct_clr_d, colct_enb_d, frame_done_d;
  logic          shift_end_c, on_done_c, last_plane_c, last_row_c;
  logic [TW-1:0] on_time_c;

  // Also stop at the last column so a missed terminal flag cannot overrun the chain.
  assign shift_end_c  = colct_eq_max || (col >= COL_W'(LAST_COL));
  assign last_plane_c = (plane == PB'(BPP - 1));
  assign last_row_c   = (shift_row == RA'(ROW_PAIRS - 1));
  assign on_time_c    = TW'(BASE_ON) << plane;
  assign fb_addr      = {shift_row, plane, col};

  hub75_oe_timer #(.TW(TW)) u_oe_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_LATCH),
    .load_val (on_time_c),
    .run      (state == S_DISPLAY),
    .done_c   (on_done_c)
  );

  // Next state, scan position and registered output values.
  always_comb begin
    state_d      = state;
    shift_row_d  = shift_row;
    row_addr_d   = row_addr;
    plane_d      = plane;
    frame_done_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_SHIFT_LO;
          shift_row_d = '0;
          plane_d     = '0;
          row_addr_d  = '0;
        end
      end
      S_SHIFT_LO: state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        if (shift_end_c) begin
          state_d    = S_BLANK;
          row_addr_d = shift_row;
        end else begin
          state_d = S_SHIFT_LO;
        end
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: state_d = S_DISPLAY;
      S_DISPLAY: begin
        if (on_done_c) begin
          if (last_plane_c) begin
            plane_d      = '0;
            shift_row_d  = last_row_c ? '0 : shift_row + RA'(1);
            frame_done_d = last_row_c;
          end else begin
            plane_d = plane + PB'(1);
          end
          if (enable) begin
            state_d = S_SHIFT_LO;
          end else begin
            state_d     = S_IDLE;
            plane_d     = '0;
            shift_row_d = '0;
            row_addr_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    sclk_d      = (state_d == S_SHIFT_HI);
    lat_d       = (state_d == S_LATCH);
    oe_n_d      = (state_d != S_DISPLAY);
    fb_rd_en_d  = (state_d == S_SHIFT_LO);
    colct_enb_d = (state_d == S_SHIFT_HI) && !shift_end_c;
    colct_clr_d = (state_d == S_IDLE) || ((state_d == S_SHIFT_HI) && shift_end_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shift_row  <= '0;
      row_addr   <= '0;
      plane      <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      fb_rd_en   <= 1'b0;
      colct_clr  <= 1'b1;
      colct_enb  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift_row  <= shift_row_d;
      row_addr   <= row_addr_d;
      plane      <= plane_d;
      sclk       <= sclk_d;
      lat        <= lat_d;
      oe_n       <= oe_n_d;
      fb_rd_en   <= fb_rd_en_d;
      colct_clr  <= colct_clr_d;
      colct_enb  <= colct_enb_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: two configurations against a plane-timeline model.
module tb_hub75_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable;

  logic [7:0]  col0, col1;
  logic        eqm0, clr0, enb0, rd0, sclk0, lat0, oe0, fd0;
  logic        eqm1, clr1, enb1, rd1, sclk1, lat1, oe1, fd1;
  logic [12:0] fba0;
  logic [9:0]  fba1;
  logic [2:0]  row0;
  logic [0:0]  row1;
  logic [1:0]  pl0;
  logic [0:0]  pl1;

  hub75_scan_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col(col0), .colct_eq_max(eqm0),
    .colct_clr(clr0), .colct_enb(enb0), .fb_rd_en(rd0), .fb_addr(fba0), .sclk(sclk0),
    .lat(lat0), .oe_n(oe0), .row_addr(row0), .plane(pl0), .frame_done(fd0)
  );

  hub75_scan_ctrl #(.NUM_PANELS(2), .ROW_PAIRS(2), .BPP(2), .BASE_ON(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .col(col1), .colct_eq_max(eqm1),
    .colct_clr(clr1), .colct_enb(enb1), .fb_rd_en(rd1), .fb_addr(fba1), .sclk(sclk1),
    .lat(lat1), .oe_n(oe1), .row_addr(row1), .plane(pl1), .frame_done(fd1)
  );

  // External column counters
  always_ff @(posedge clk) begin
    if (!rst_n || clr0) col0 <= 8'd0;
    else if (enb0)      col0 <= col0 + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr1) col1 <= 8'd0;
    else if (enb1)      col1 <= col1 + 8'd1;
  end
  assign eqm0 = (col0 == 8'd31);
  assign eqm1 = (col1 == 8'd63);

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
  endtask

  function automatic int np_of(input int i);   return (i == 0) ? 1 : 2; endfunction
  function automatic int rp_of(input int i);   return (i == 0) ? 8 : 2; endfunction
  function automatic int bpp_of(input int i);  return (i == 0) ? 4 : 2; endfunction
  function automatic int base_of(input int i); return (i == 0) ? 8 : 4; endfunction
  function automatic int pbw_of(input int i);  return (i == 0) ? 2 : 1; endfunction

  // Clocks taken by one plane: shift, blank, latch, weighted display.
  function automatic int plen(input int i, input int p);
    return 64 * np_of(i) + 2 + (base_of(i) << p);
  endfunction

  // Model: running flag, plane sequence number since start, offset within that plane.
  bit armed = 1'b0;
  int m_run[2];
  int m_seq[2];
  int m_off[2];
  bit m_fd[2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_seq[i] = 0; m_off[i] = 0; m_fd[i] = 1'b0;
      end else if (m_run[i] == 0) begin
        m_fd[i] = 1'b0;
        if (enable) begin m_run[i] = 1; m_seq[i] = 0; m_off[i] = 0; end
      end else if (m_off[i] == plen(i, m_seq[i] % bpp_of(i)) - 1) begin
        m_fd[i] = (m_seq[i] % bpp_of(i) == bpp_of(i) - 1) &&
                  ((m_seq[i] / bpp_of(i)) % rp_of(i) == rp_of(i) - 1);
        if (enable) begin m_seq[i]++; m_off[i] = 0; end
        else begin m_run[i] = 0; m_seq[i] = 0; m_off[i] = 0; end
      end else begin
        m_off[i]++;
        m_fd[i] = 1'b0;
      end
    end
    if (!rst_n) armed = 1'b1;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int p, r, sl, c, last, e_row, e_pl;
      logic e_sclk, e_lat, e_oe, e_rd, e_clr, e_enb, fbchk;
      logic [31:0] e_fba, a_fba;
      logic [15:0] e_v, a_v;
      e_sclk = 1'b0; e_lat = 1'b0; e_oe = 1'b1; e_rd = 1'b0; e_clr = 1'b1; e_enb = 1'b0;
      e_row = 0; e_pl = 0; fbchk = 1'b0; e_fba = 32'd0;
      if (m_run[i] != 0) begin
        p     = m_seq[i] % bpp_of(i);
        r     = (m_seq[i] / bpp_of(i)) % rp_of(i);
        sl    = 64 * np_of(i);
        last  = 32 * np_of(i) - 1;
        e_pl  = p;
        e_clr = 1'b0;
        if (m_off[i] < sl) begin
          c      = m_off[i] / 2;
          e_sclk = (m_off[i] % 2) == 1;
          e_rd   = !e_sclk;
          e_enb  = e_sclk && (c != last);
          e_clr  = e_sclk && (c == last);
          e_row  = (m_seq[i] == 0) ? 0 : ((m_seq[i] - 1) / bpp_of(i)) % rp_of(i);
          fbchk  = 1'b1;
          e_fba  = 32'((r << (pbw_of(i) + 8)) | (p << 8) | c);
        end else begin
          e_row = r;
          e_lat = (m_off[i] == sl + 1);
          e_oe  = (m_off[i] < sl + 2);
        end
      end
      e_v = {e_sclk, e_lat, e_oe, e_rd, e_clr, e_enb, m_fd[i], 5'(e_row), 4'(e_pl)};
      if (i == 0) begin
        a_v   = {sclk0, lat0, oe0, rd0, clr0, enb0, fd0, 5'(row0), 4'(pl0)};
        a_fba = 32'(fba0);
      end else begin
        a_v   = {sclk1, lat1, oe1, rd1, clr1, enb1, fd1, 5'(row1), 4'(pl1)};
        a_fba = 32'(fba1);
      end
      check($sformatf("dut%0d_outputs", i), 32'(a_v), 32'(e_v));
      if (fbchk) check($sformatf("dut%0d_fb_addr", i), a_fba, e_fba);
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); if (armed) compare_all(); end

  initial begin
    int sc0, sc1, on_cnt, ovl, run_len, max_run, max_start, fd_cnt, fd_t, k;
    logic prev0, prev1;
    sc0 = 0; sc1 = 0; on_cnt = 0; ovl = 0; run_len = 0; max_run = 0; max_start = 0;
    fd_cnt = 0; fd_t = 0; prev0 = 1'b0; prev1 = 1'b0;

    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe_n", 32'(oe0), 32'd1);
    check("rst_colct_clr", 32'(clr0), 32'd1);
    check("rst_sclk_lat", 32'({sclk0, lat0}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_oe_clr", 32'({oe0, clr0}), 32'd3);

    // Continuous scan from IDLE; t counts clocks since enable was sampled.
    enable = 1'b1;
    for (int t = 1; t <= 3140; t++) begin
      @(negedge clk);
      if (t <= 64 && sclk0 && !prev0) sc0++;
      if (t <= 128 && sclk1 && !prev1) sc1++;
      prev0 = sclk0; prev1 = sclk1;
      if (t == 65) check("lat_before_66", 32'(lat0), 32'd0);
      if (t == 66) check("lat_at_66", 32'({lat0, oe0}), 32'd3);
      if (t == 67) check("lat_after_66", 32'(lat0), 32'd0);
      if (t >= 67 && t <= 74 && !oe0) on_cnt++;
      if (t == 75) check("plane1_at_75", 32'({oe0, pl0}), 32'b101);
      if (t <= 400) begin
        if (!oe0) begin
          run_len++;
          if (run_len > max_run) begin max_run = run_len; max_start = t - run_len + 1; end
        end else run_len = 0;
      end
      if (lat0 && !oe0) ovl++;
      if (t <= 3073 && fd0) begin fd_cnt++; if (fd_t == 0) fd_t = t; end
      if (t == 3136) check("row_addr_before_wrap", 32'(row0), 32'd7);
      if (t == 3137) check("row_addr_wrapped", 32'(row0), 32'd0);
      if (t == 127) check("p2_eqmax_col63", 32'({eqm1, col1}), 32'h13f);
      if (t == 128) check("p2_clr_after_max", 32'({clr1, enb1}), 32'b10);
    end
    check("sclk_edges_p1", 32'(sc0), 32'd32);
    check("sclk_edges_p2", 32'(sc1), 32'd64);
    check("plane0_on_clocks", 32'(on_cnt), 32'd8);
    check("plane3_on_run", 32'(max_run), 32'd64);
    check("plane3_on_start", 32'(max_start), 32'd321);
    check("oe_lat_overlap", 32'(ovl), 32'd0);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("frame_done_time", 32'(fd_t), 32'd3073);

    // Reset in the middle of DISPLAY
    k = 0;
    while (oe0 !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
    check("wait_display", 32'(k < 1000), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_oe_lat_sclk", 32'({oe0, lat0, sclk0}), 32'b100);
    check("midrst_clr_row_plane", 32'({clr0, row0, pl0}), 32'b1_000_00);
    rst_n = 1'b1;

    // Drop enable during SHIFT_HI of row 2: that plane still finishes, then IDLE.
    k = 0;
    while (!(m_run[0] != 0 && m_seq[0] == 8 && sclk0 === 1'b1) && k < 2000) begin
      @(negedge clk); k++;
    end
    check("wait_row2_shift", 32'(k < 2000), 32'd1);
    enable = 1'b0;
    k = 0;
    while (oe0 !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    check("wait_drop_display", 32'(k < 300), 32'd1);
    on_cnt = 0;
    while (oe0 === 1'b0 && on_cnt < 300) begin @(negedge clk); on_cnt++; end
    check("drop_on_clocks", 32'(on_cnt), 32'd8);
    check("drop_idle_clr", 32'({clr0, row0, pl0}), 32'b1_000_00);
    repeat (10) @(negedge clk);
    check("drop_stays_idle", 32'({oe0, sclk0, clr0}), 32'b101);

    // Randomised enable and occasional reset
    enable = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 1999) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
